// File: rtl/clock_pkg.sv
// Shared definitions for the desk clock: mode encoding seen by the clock core
// and the state/target types of the time-set controller.
package clock_pkg;

  localparam logic [1:0] MODE_COUNTING      = 2'd0;
  localparam logic [1:0] MODE_SET_MINUTES   = 2'd1;
  localparam logic [1:0] MODE_SET_HOURS     = 2'd2;
  localparam logic [1:0] MODE_CLEAR_SECONDS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_SLOW  = 3'd2,
    ST_FAST  = 3'd3,
    ST_CLEAR = 3'd4
  } ctrl_state_t;

  typedef enum logic {
    TGT_MIN = 1'b0,
    TGT_HR  = 1'b1
  } set_target_t;

endpackage

// File: rtl/timeset_controller.sv
// Button sequencer for the time register: derives clock mode and timeset strobe
// with press-and-hold acceleration and a both-buttons clear-seconds chord.
module timeset_controller
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_STEPS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_minutes,
  input  logic       i_btn_hours,
  input  logic       i_slow_set_stb,
  input  logic       i_fast_set_stb,
  output logic [1:0] o_mode,
  output logic       o_timeset_stb
);

  ctrl_state_t state, state_d;
  set_target_t target, target_d;
  logic [7:0]  hold, hold_d;
  logic [1:0]  mode_d;
  logic        stb_d;

  logic        tgt_btn;
  logic        oth_btn;
  logic [8:0]  hold_inc;
  logic [8:0]  hold_lim;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      target        <= TGT_MIN;
      hold          <= '0;
      o_mode        <= MODE_COUNTING;
      o_timeset_stb <= 1'b0;
    end else begin
      state         <= state_d;
      target        <= target_d;
      hold          <= hold_d;
      o_mode        <= mode_d;
      o_timeset_stb <= stb_d;
    end
  end

  always_comb begin
    state_d  = state;
    target_d = target;
    hold_d   = hold;
    tgt_btn  = (target == TGT_HR) ? i_btn_hours   : i_btn_minutes;
    oth_btn  = (target == TGT_HR) ? i_btn_minutes : i_btn_hours;
    hold_inc = {1'b0, hold} + 9'd1;
    hold_lim = 9'(HOLD_STEPS);
    unique case (state)
      ST_IDLE: begin
        if (i_btn_minutes && i_btn_hours) begin
          state_d = ST_CLEAR;
        end else if (i_btn_minutes) begin
          state_d  = ST_FIRST;
          target_d = TGT_MIN;
          hold_d   = '0;
        end else if (i_btn_hours) begin
          state_d  = ST_FIRST;
          target_d = TGT_HR;
          hold_d   = '0;
        end
      end
      ST_FIRST, ST_SLOW, ST_FAST: begin
        // Button exits win over any rate strobe sampled in the same cycle.
        if (!tgt_btn) begin
          state_d = ST_IDLE;
        end else if (oth_btn) begin
          state_d = ST_CLEAR;
        end else if (state == ST_FIRST) begin
          state_d = ST_SLOW;
        end else if (state == ST_SLOW && i_slow_set_stb) begin
          if (hold_inc >= hold_lim) begin
            hold_d  = hold_lim[7:0];
            state_d = ST_FAST;
          end else begin
            hold_d  = hold_inc[7:0];
          end
        end
      end
      ST_CLEAR: begin
        if (!i_btn_minutes && !i_btn_hours) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge.
  always_comb begin
    unique case (state_d)
      ST_IDLE:  mode_d = MODE_COUNTING;
      ST_CLEAR: mode_d = MODE_CLEAR_SECONDS;
      default:  mode_d = (target_d == TGT_HR) ? MODE_SET_HOURS : MODE_SET_MINUTES;
    endcase
    stb_d = (state_d == ST_FIRST)
          || (state_d == ST_CLEAR && state != ST_CLEAR)
          || (state == ST_SLOW && (state_d == ST_SLOW || state_d == ST_FAST) && i_slow_set_stb)
          || (state == ST_FAST && state_d == ST_FAST && i_fast_set_stb);
  end

endmodule

// File: tb/tb_timeset_controller.sv
// Directed bench for timeset_controller: taps, hold acceleration, chord clear,
// release/strobe collisions and asynchronous reset.
module tb_timeset_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_m = 1'b0;
  logic       btn_h = 1'b0;
  logic       slow = 1'b0;
  logic       fast = 1'b0;
  logic [1:0] mode;
  logic       stb;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stb_count;

  timeset_controller #(.HOLD_STEPS(4)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_btn_minutes  (btn_m),
    .i_btn_hours    (btn_h),
    .i_slow_set_stb (slow),
    .i_fast_set_stb (fast),
    .o_mode         (mode),
    .o_timeset_stb  (stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    stb_count += (stb === 1'b1) ? 1 : 0;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] m, input logic s);
    chk({tag, ".mode"}, 32'(mode), 32'(m));
    chk({tag, ".stb"}, 32'(stb), 32'(s));
  endtask

  // Press one button and walk through FIRST, SLOW and the four slow steps into FAST.
  task automatic goto_fast(input logic hrs);
    logic [1:0] m;
    m = hrs ? 2'd2 : 2'd1;
    btn_h = hrs;
    btn_m = !hrs;
    step(); expect_out("gf_first", m, 1'b1);
    step(); expect_out("gf_slow", m, 1'b0);
    for (int i = 0; i < 4; i++) begin
      slow = 1'b1; step(); expect_out("gf_slowstb", m, 1'b1);
      slow = 1'b0; step(); expect_out("gf_gap", m, 1'b0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stb_count = 0;
    // Reset state
    #3;
    expect_out("reset", 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(); expect_out("idle", 2'd0, 1'b0);
    slow = 1'b1; fast = 1'b1;
    step(); expect_out("idle_stb", 2'd0, 1'b0);
    slow = 1'b0; fast = 1'b0;

    // Tap minutes for 3 cycles
    stb_count = 0;
    btn_m = 1'b1;
    step(); expect_out("tap1", 2'd1, 1'b1);
    step(); expect_out("tap2", 2'd1, 1'b0);
    step(); expect_out("tap3", 2'd1, 1'b0);
    btn_m = 1'b0;
    step(); expect_out("tap_rel", 2'd0, 1'b0);
    chk("tap_count", stb_count, 1);

    // Hold hours: 6 slow strobes then 3 fast strobes -> 8 total
    stb_count = 0;
    btn_h = 1'b1;
    step(); expect_out("hold_first", 2'd2, 1'b1);
    step(); expect_out("hold_slow", 2'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      slow = 1'b1; step(); expect_out("hold_slowstb", 2'd2, (i < 4) ? 1'b1 : 1'b0);
      slow = 1'b0; step(); expect_out("hold_slowgap", 2'd2, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      fast = 1'b1; step(); expect_out("hold_faststb", 2'd2, 1'b1);
      fast = 1'b0; step(); expect_out("hold_fastgap", 2'd2, 1'b0);
    end
    chk("hold_count", stb_count, 8);
    btn_h = 1'b0;
    step(); expect_out("hold_rel", 2'd0, 1'b0);

    // Release minutes in the same cycle as a fast strobe
    goto_fast(1'b0);
    fast = 1'b1; btn_m = 1'b0;
    step(); expect_out("rel_fast", 2'd0, 1'b0);
    fast = 1'b0;
    step(); expect_out("rel_after", 2'd0, 1'b0);

    // Strobe during FIRST is ignored
    btn_m = 1'b1;
    step(); expect_out("first_in", 2'd1, 1'b1);
    slow = 1'b1;
    step(); expect_out("first_ign", 2'd1, 1'b0);
    slow = 1'b0;

    // Hours pressed while holding minutes -> CLEAR
    btn_h = 1'b1;
    step(); expect_out("chord_in", 2'd3, 1'b1);
    step(); expect_out("chord_hold", 2'd3, 1'b0);
    btn_h = 1'b0;
    step(); expect_out("chord_h_rel", 2'd3, 1'b0);
    btn_m = 1'b0;
    step(); expect_out("chord_rel", 2'd0, 1'b0);

    // Asynchronous reset in FAST, hours held through deassertion
    goto_fast(1'b1);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 2'd0, 1'b0);
    @(posedge clk); #1;
    expect_out("rst_held", 2'd0, 1'b0);
    rst_n = 1'b1;
    step(); expect_out("rst_fresh", 2'd2, 1'b1);
    btn_h = 1'b0;
    step(); expect_out("rst_rel", 2'd0, 1'b0);

    // Both buttons together from IDLE -> CLEAR directly
    btn_m = 1'b1; btn_h = 1'b1;
    step(); expect_out("both_in", 2'd3, 1'b1);
    step(); expect_out("both_hold", 2'd3, 1'b0);
    btn_m = 1'b0; btn_h = 1'b0;
    step(); expect_out("both_rel", 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timeset_controller.md
# timeset_controller

Button-driven sequencer for the desk clock's time register. Turns the hours/minutes set buttons into the 2-bit clock mode and the timeset strobe that the clock datapath consumes, with press-and-hold acceleration from the slow set rate to the fast set rate, and a both-buttons chord that clears seconds. Sits between the debounced button inputs and the clock core; the strobe sources come from the shared prescaler.

## Interface

Parameters:
- HOLD_STEPS, 4, slow-rate steps delivered before switching to the fast rate; legal range 1..255

Ports:
- i_clk, input, 1, system clock (~50 MHz)
- i_reset_n, input, 1, reset; asynchronous, active-low
- i_btn_minutes, input, 1, minutes-set button; active-high, already synchronized and debounced to i_clk
- i_btn_hours, input, 1, hours-set button; same conditioning as i_btn_minutes
- i_slow_set_stb, input, 1, single-cycle strobe at SLOW_SET_HZ
- i_fast_set_stb, input, 1, single-cycle strobe at FAST_SET_HZ
- o_mode, output, 2, clock mode: 0 COUNTING, 1 SET_MINUTES, 2 SET_HOURS, 3 CLEAR_SECONDS
- o_timeset_stb, output, 1, single-cycle strobe to the clock core's timeset input

## Operation

- States: IDLE, FIRST, SLOW, FAST, CLEAR. A target register (MIN/HR) is loaded on entry to FIRST.
- IDLE:
  - o_mode = 0.
  - Both buttons high → CLEAR.
  - Minutes only → FIRST with target MIN.
  - Hours only → FIRST with target HR.
- FIRST:
  - o_mode = target mode (1 or 2).
  - Emits exactly one strobe, so a short tap gives one step.
  - Unconditionally moves to SLOW next cycle with the hold counter cleared.
  - Input strobes arriving in FIRST are ignored.
- SLOW:
  - Each i_slow_set_stb produces one output strobe and increments the hold counter.
  - The strobe that brings the count to HOLD_STEPS is still forwarded; the state then moves to FAST.
- FAST: each i_fast_set_stb produces one output strobe. Stays in FAST until a button changes.
- Any of FIRST/SLOW/FAST:
  - Target button released → IDLE.
  - Other button also pressed → CLEAR.
  - Either exit takes priority over any strobe in the same cycle; that strobe is dropped.
- CLEAR:
  - o_mode = 3.
  - One output strobe on entry.
  - Stays in CLEAR until both buttons are low, then → IDLE. Never returns directly to a set state.
- Hold counter:
  - 8 bits.
  - Saturates at HOLD_STEPS.
  - Cleared on every FIRST entry.

## Timing

- Reset values: o_mode = 0, o_timeset_stb = 0, state IDLE, target MIN, hold counter 0.
- Both outputs are registered and update on the same i_clk edge, so o_mode is always valid in the cycle o_timeset_stb is high.
- Button press:
  - Press sampled at edge N: state/o_mode change at N; o_timeset_stb high at N (FIRST) for one cycle.
  - o_mode is never 0 while o_timeset_stb is high.
- Strobe latency: i_slow_set_stb/i_fast_set_stb high in cycle K → o_timeset_stb high in cycle K+1, width 1.
- Release: button low sampled at edge N → o_mode = 0 and o_timeset_stb = 0 from N. No trailing strobe.
- Both buttons rising in the same cycle from IDLE → CLEAR directly, never through FIRST.
- Reset asserted mid-operation (any state) → outputs return to reset values asynchronously. A button held through reset deassertion is treated as a fresh press.

## Structure

- Shared package clock_pkg holds:
  - the mode encoding constants (MODE_COUNTING, MODE_SET_MINUTES, MODE_SET_HOURS, MODE_CLEAR_SECONDS), used by both this block and the clock core;
  - the controller state enum.
- No sub-module. The hold counter and FSM fit in one module.

## Test plan

- Tap minutes for 3 cycles, no slow strobe → o_mode = 1 for 3 cycles, exactly one o_timeset_stb, then o_mode = 0.
- Hold hours, HOLD_STEPS = 4, feed 6 slow strobes then 3 fast strobes:
  - 6 + 3 + 1 (FIRST) strobes at K+1 latency would follow if all rates were forwarded; required result is 1 (FIRST) + 4 slow + 3 fast = 8 strobes.
  - Slow strobes 5–6 are ignored in FAST.
  - o_mode = 2 throughout.
- Release minutes in the same cycle as i_fast_set_stb → no output strobe; o_mode = 0 at the next edge.
- While holding minutes, press hours:
  - o_mode = 3 with one strobe.
  - Release hours only → stays in CLEAR.
  - Release both → IDLE.
- Assert i_reset_n low while in FAST → o_mode = 0 and o_timeset_stb = 0 immediately, without waiting for a clock edge.
- Both buttons rising together from IDLE → o_mode goes 0→3 with no intermediate 1 or 2, and one strobe.
